// File: rtl/btn_event_queue.sv
// btn_event_queue
// Collects one-cycle button press pulses into a small event FIFO. Each press
// latches a pending bit. A priority arbiter (lowest button index wins) pushes
// one pending button index per cycle into the FIFO. A consumer pops events
// with a valid/ready handshake.
//
// Ports
//   clk        : system clock, rising-edge only
//   reset      : synchronous, active-high reset
//   i_btn      : one-cycle press pulses, bit n = button n
//   i_ready    : consumer accepts the head event when o_valid is also 1
//   o_valid    : registered, FIFO holds at least one event
//   o_code     : button index at the FIFO head (meaningful when o_valid=1)
//   o_count    : number of events held, 0..DEPTH
//   o_overflow : sticky, a press merged into an already-pending one (lost)
module btn_event_queue #(
  parameter int N_BTN = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_BTN-1:0]           i_btn,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [$clog2(N_BTN)-1:0]   o_code,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int CW   = $clog2(N_BTN);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

  logic [N_BTN-1:0] r_pend;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_mem [DEPTH];

  logic             w_pop;
  logic             w_push;
  logic [N_BTN-1:0] w_grant;
  logic [CW-1:0]    w_gidx;
  logic [CNTW-1:0]  w_count_next;
  logic             w_merge;

  // Handshake and arbitration: the lowest-index pending button wins. A full
  // FIFO can still take a push when the head leaves on the same edge.
  always_comb begin
    w_gidx  = '0;
    w_grant = '0;
    w_pop   = o_valid & i_ready;
    w_push  = (|r_pend) & ((o_count < FULL_COUNT) | w_pop);
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_gidx = i[CW-1:0];
      end else begin
        w_gidx = w_gidx;
      end
    end
    if (w_push) begin
      w_grant[w_gidx] = 1'b1;
    end else begin
      w_grant = '0;
    end
  end

  // Occupancy update and loss detection. A re-press on the granted bit is not
  // a loss because the grant clears the old pending request on that same edge.
  always_comb begin
    w_count_next = o_count;
    w_merge      = |(i_btn & r_pend & ~w_grant);
    case ({w_push, w_pop})
      2'b10:   w_count_next = o_count + CNTW'(1);
      2'b01:   w_count_next = o_count - CNTW'(1);
      default: w_count_next = o_count;
    endcase
  end

  // Control state: pending bits, pointers, count and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      o_count    <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      r_pend  <= (r_pend & ~w_grant) | i_btn;
      o_count <= w_count_next;
      o_valid <= (w_count_next != '0);
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_merge) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // Event storage: data only, no reset needed because o_valid gates its use.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= w_gidx;
    end
  end

  assign o_code = r_mem[r_rptr];

endmodule

// File: doc/btn_event_queue.md
BTN_EVENT_QUEUE -- requirements
Module: btn_event_queue

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, giving the number of debounced button pulse inputs.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of event FIFO entries (power of two, >=2).
REQ-003 clk  input  1  system clock (100 MHz); the only clock; every flop is clocked on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 i_btn  input  N_BTN  one-cycle press pulses from the per-button debounce stages; bit n corresponds to button n.
REQ-006 i_ready  input  1  consumer accepts the head event on a cycle where o_valid and i_ready are both 1.
REQ-007 o_valid  output  1  registered; the FIFO holds at least one event.
REQ-008 o_code  output  $clog2(N_BTN)  index of the button at the FIFO head; valid only when o_valid=1.
REQ-009 o_count  output  $clog2(DEPTH)+1  number of events held, 0..DEPTH.
REQ-010 o_overflow  output  1  sticky flag: a press was lost; cleared only by reset.

Function
REQ-011 Capture: a pending register pend[N_BTN-1:0] SHALL be updated each edge as pend_next = (pend & ~grant) | i_btn.
REQ-012 Arbitration: grant SHALL be one-hot on the lowest-index set bit of pend, or zero if pend=0 or push is blocked.
REQ-013 Push condition: a push occurs on an edge if pend!=0 and (o_count<DEPTH or pop occurs on the same edge).
REQ-014 Pop condition: a pop occurs on an edge if o_valid=1 and i_ready=1.
REQ-015 Push SHALL write the binary index of the granted bit at the write pointer; pop SHALL advance the read pointer; both pointers wrap modulo DEPTH.
REQ-016 o_count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push+pop or on neither.
REQ-017 o_valid SHALL equal (o_count!=0), and o_code SHALL be driven from the entry at the read pointer.
REQ-018 Latency: a pulse on i_btn[n] sampled at edge k into an empty, idle block SHALL give o_valid=1 and o_code=n after edge k+1.
REQ-019 Throughput: at most one push and one pop per cycle; with i_ready held 1, a full pend drains one event per cycle.
REQ-020 Order: events SHALL leave in push order; simultaneous pulses are pushed lowest index first on consecutive edges.
REQ-021 Merge/loss: a pulse on i_btn[n] while pend[n]=1 and grant[n]=0 SHALL be merged, and o_overflow SHALL set on that edge.
REQ-022 A pulse on i_btn[n] on the same edge that grant[n]=1 SHALL re-set pend[n] without setting o_overflow.
REQ-023 Full FIFO with no pop: pend SHALL hold its bits, no entry is overwritten, and o_count SHALL stay DEPTH.
REQ-024 Full FIFO with pop: the push SHALL proceed on the same edge, and o_count SHALL stay DEPTH.
REQ-025 Pop on empty: i_ready=1 with o_valid=0 SHALL have no effect.

Reset
REQ-026 When reset=1 at a rising edge, pend, both pointers and o_count SHALL be 0, and o_valid and o_overflow SHALL be 0.
REQ-027 FIFO storage contents SHALL NOT need a reset value; o_code is don't-care while o_valid=0.
REQ-028 Reset SHALL take priority over every push, pop and capture on the same edge, including mid-drain.
REQ-029 i_btn pulses sampled on a reset edge SHALL be discarded.

Verification
REQ-030 Single press: i_btn=4'b0100 for 1 cycle, i_ready=1 -> o_valid=1 and o_code=2 for exactly 1 cycle, 2 edges after the pulse, then o_count=0.
REQ-031 Simultaneous press: i_btn=4'b1011 for 1 cycle, i_ready=0 -> o_count reaches 3 after 3 more edges; then i_ready=1 -> o_code sequence 0,1,3.
REQ-032 Fill and stall: 6 separate pulses on btn1 spaced 2 cycles apart, i_ready=0 -> o_count=4, pend[1] held, o_overflow=1 at the 6th pulse, and 4 entries of code 1 are retained.
REQ-033 Full with pop: with the FIFO full and pend[0]=1, assert i_ready=1 for 1 cycle -> o_count stays 4 and the tail entry is code 0.
REQ-034 Re-press at grant: pulse btn2 on the edge where it is granted -> two code-2 events are queued and o_overflow stays 0.
REQ-035 Mid-operation reset: with o_count=3 and pend!=0, assert reset for 1 cycle -> o_valid=0, o_count=0, o_overflow=0 and pend=0 on the next cycle.
